// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: FSM states, funct3 encodings
// for base and M-extension operations, and the M-extension funct7 code.
package alu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } alu_state_e;

    // Base integer operations (funct3)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Multiply/divide operations (funct3 when funct7 == FUNCT7_MULDIV)
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

endpackage

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide engine: one bit per cycle over WIDTH cycles.
// Operands are converted to magnitudes on start; the sign is reapplied to
// the combinational result of the final step, so the caller can latch
// 'result' in the same cycle that 'last' is high.
module muldiv_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             step,
    input  logic [2:0]       funct3,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] result
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] hi;      // product high half / partial remainder
    logic [WIDTH-1:0] lo;      // multiplier bits / dividend-then-quotient
    logic [WIDTH-1:0] mcand;   // multiplicand magnitude / divisor magnitude
    logic             neg;     // negate the final selected result
    logic [2:0]       op_f3;

    logic             is_div_s, a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0]   mul_sum, div_shift, div_trial;
    logic [WIDTH-1:0] hi_n, lo_n, div_val, div_res, mul_res;
    logic [2*WIDTH-1:0] prod, prod_s;

    // Start-time decode: which operands are signed, and their magnitudes
    always_comb begin
        is_div_s = funct3[2];
        a_signed = is_div_s ? ~funct3[0] : (funct3 == F3_MULH || funct3 == F3_MULHSU);
        b_signed = is_div_s ? ~funct3[0] : (funct3 == F3_MULH);
        a_neg    = a_signed & a[WIDTH-1];
        b_neg    = b_signed & b[WIDTH-1];
        a_mag    = a_neg ? (~a + 1'b1) : a;
        b_mag    = b_neg ? (~b + 1'b1) : b;
    end

    // One shift-add or restoring-divide step, plus sign-corrected result
    always_comb begin
        mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
        div_shift = {hi, lo[WIDTH-1]};
        div_trial = div_shift - {1'b0, mcand};
        if (op_f3[2]) begin
            if (!div_trial[WIDTH]) begin
                hi_n = div_trial[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b1};
            end else begin
                hi_n = div_shift[WIDTH-1:0];
                lo_n = {lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_n = mul_sum[WIDTH:1];
            lo_n = {mul_sum[0], lo[WIDTH-1:1]};
        end
        prod    = {hi_n, lo_n};
        prod_s  = neg ? (~prod + 1'b1) : prod;
        mul_res = (op_f3[1:0] == 2'b00) ? prod_s[WIDTH-1:0] : prod_s[2*WIDTH-1:WIDTH];
        div_val = op_f3[1] ? hi_n : lo_n;
        div_res = neg ? (~div_val + 1'b1) : div_val;
        result  = op_f3[2] ? div_res : mul_res;
        last    = (cnt == '0);
    end

    // Load magnitudes on start, then iterate while the caller holds 'step'
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            neg   <= 1'b0;
            op_f3 <= '0;
        end else if (start) begin
            cnt   <= CW'(WIDTH - 1);
            hi    <= '0;
            lo    <= is_div_s ? a_mag : b_mag;
            mcand <= is_div_s ? b_mag : a_mag;
            // Remainder takes the dividend's sign; everything else the product sign
            neg   <= (is_div_s && funct3[1]) ? a_neg : (a_neg ^ b_neg);
            op_f3 <= funct3;
        end else if (step) begin
            hi <= hi_n;
            lo <= lo_n;
            if (cnt != '0) cnt <= cnt - CW'(1);
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential RV32I/RV32M ALU. Base operations finish one cycle after
// accept; multiply/divide run through muldiv_seq for WIDTH cycles.
// Handshake: an operation moves on a cycle where in_valid && in_ready;
// a result moves on a cycle where out_valid && out_ready. Outputs hold
// while out_valid is high and out_ready is low.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs1_data,
    input  logic [WIDTH-1:0] rs2_data,
    input  logic [WIDTH-1:0] Iimm,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic             isALUreg,
    input  logic             isBranch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] aluOut,
    output logic             EQ,
    output logic             LT,
    output logic             LTU,
    output logic             busy,
    output alu_state_e       state_dbg
);

    localparam int SW = $clog2(WIDTH);

    alu_state_e       state;
    logic             accept, is_mop, div_zero, div_ovf, md_go, md_start, md_step;
    logic             md_last, eq_c, lt_c, ltu_c, pend_eq, pend_lt, pend_ltu;
    logic [WIDTH-1:0] alu_in2, base_res, special_res, md_result;
    logic [SW-1:0]    shamt;
    logic [WIDTH:0]   minus;

    // Operand selection, compare flags, base ops and divide special cases
    always_comb begin
        accept   = in_valid && (state == IDLE);
        alu_in2  = (isALUreg || isBranch) ? rs2_data : Iimm;
        shamt    = isALUreg ? rs2_data[SW-1:0] : Iimm[SW-1:0];
        is_mop   = isALUreg && (funct7 == FUNCT7_MULDIV);
        minus    = {1'b0, rs1_data} - {1'b0, alu_in2};
        eq_c     = (minus[WIDTH-1:0] == '0);
        ltu_c    = minus[WIDTH];
        lt_c     = (rs1_data[WIDTH-1] ^ alu_in2[WIDTH-1]) ? rs1_data[WIDTH-1] : minus[WIDTH];
        div_zero = (rs2_data == '0);
        div_ovf  = ~funct3[0] && (rs1_data == {1'b1, {(WIDTH-1){1'b0}}}) && (rs2_data == '1);
        if (div_zero)
            special_res = funct3[1] ? rs1_data : '1;
        else
            special_res = funct3[1] ? '0 : rs1_data;
        md_go    = is_mop && !(funct3[2] && (div_zero || div_ovf));
        md_start = accept && md_go;
        md_step  = (state == MUL) || (state == DIV);
        case (funct3)
            F3_ADD:  base_res = (isALUreg && funct7[5]) ? minus[WIDTH-1:0] : rs1_data + alu_in2;
            F3_SLL:  base_res = rs1_data << shamt;
            F3_SLT:  base_res = {{(WIDTH-1){1'b0}}, lt_c};
            F3_SLTU: base_res = {{(WIDTH-1){1'b0}}, ltu_c};
            F3_XOR:  base_res = rs1_data ^ alu_in2;
            F3_SR:   base_res = funct7[5] ? WIDTH'($signed(rs1_data) >>> shamt) : rs1_data >> shamt;
            F3_OR:   base_res = rs1_data | alu_in2;
            default: base_res = rs1_data & alu_in2;
        endcase
        in_ready  = (state == IDLE);
        busy      = (state != IDLE);
        state_dbg = state;
    end

    muldiv_seq #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .step   (md_step),
        .funct3 (funct3),
        .a      (rs1_data),
        .b      (rs2_data),
        .last   (md_last),
        .result (md_result)
    );

    // Control FSM with registered result, flags and out_valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            aluOut    <= '0;
            EQ        <= 1'b0;
            LT        <= 1'b0;
            LTU       <= 1'b0;
            out_valid <= 1'b0;
            pend_eq   <= 1'b0;
            pend_lt   <= 1'b0;
            pend_ltu  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (md_go) begin
                            // Flags wait in pend_* so they appear together with the result
                            pend_eq  <= eq_c;
                            pend_lt  <= lt_c;
                            pend_ltu <= ltu_c;
                            state    <= funct3[2] ? DIV : MUL;
                        end else begin
                            aluOut    <= is_mop ? special_res : base_res;
                            EQ        <= eq_c;
                            LT        <= lt_c;
                            LTU       <= ltu_c;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end
                    end
                end
                MUL, DIV: begin
                    if (md_last) begin
                        aluOut    <= md_result;
                        EQ        <= pend_eq;
                        LT        <= pend_lt;
                        LTU       <= pend_ltu;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq: hand-computed results, flags and latencies,
// output hold under back-pressure, and reset in the middle of a divide.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk, rst_n, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0] rs1_data, rs2_data, Iimm, aluOut;
    logic [2:0]   funct3;
    logic [6:0]   funct7;
    logic         isALUreg, isBranch, EQ, LT, LTU, busy;
    alu_state_e   state_dbg;

    int           n_checks;
    int           n_pass;
    logic [W-1:0] exp_q[$];

    alu_seq #(.WIDTH(W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .Iimm(Iimm),
        .funct3(funct3), .funct7(funct7), .isALUreg(isALUreg), .isBranch(isBranch),
        .out_valid(out_valid), .out_ready(out_ready), .aluOut(aluOut),
        .EQ(EQ), .LT(LT), .LTU(LTU), .busy(busy), .state_dbg(state_dbg)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] imm,
                         input logic [2:0] f3, input logic [6:0] f7, input logic isreg, input logic isbr);
        rs1_data = a;
        rs2_data = b;
        Iimm     = imm;
        funct3   = f3;
        funct7   = f7;
        isALUreg = isreg;
        isBranch = isbr;
    endtask

    // Issue one operation, wait for its result, optionally back-pressure, then take it
    task automatic run_op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W-1:0] imm, input logic [2:0] f3, input logic [6:0] f7,
                          input logic isreg, input logic isbr, input logic [W-1:0] exp_res,
                          input logic [2:0] exp_flags, input int exp_lat, input int hold);
        int           lat;
        logic         busy_ok;
        logic [W-1:0] e;
        exp_q.push_back(exp_res);
        @(negedge clk);
        for (int i = 0; i < 100 && !in_ready; i++) @(negedge clk);
        drive(a, b, imm, f3, f7, isreg, isbr);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat      = 1;
        busy_ok  = 1'b1;
        while (!out_valid && lat < 200) begin
            busy_ok &= busy;
            @(posedge clk);
            #1;
            lat++;
        end
        busy_ok &= busy;
        e = exp_q.pop_front();
        check({tag, "_lat"}, W'(lat), W'(exp_lat));
        check({tag, "_out"}, aluOut, e);
        check({tag, "_flags"}, W'({EQ, LT, LTU}), W'(exp_flags));
        check({tag, "_busy"}, W'(busy_ok), W'(1));
        // A competing request during back-pressure must be ignored
        if (hold > 0) begin
            drive(32'h1234_5678, 32'h1, 32'h1, F3_ADD, 7'h00, 1'b0, 1'b0);
            in_valid = 1'b1;
        end
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            check({tag, "_hold_out"}, aluOut, e);
            check({tag, "_hold_rdy"}, W'(in_ready), W'(0));
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_ovld_drop"}, W'(out_valid), W'(0));
        check({tag, "_idle"}, W'(state_dbg), W'(IDLE));
    endtask

    initial begin
        int   cyc;
        logic stale;
        n_checks  = 0;
        n_pass    = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive('0, '0, '0, 3'b000, 7'h00, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check("rst_out", aluOut, 32'h0);
        check("rst_ovld", W'(out_valid), W'(0));
        check("rst_busy", W'(busy), W'(0));
        check("rst_rdy", W'(in_ready), W'(1));
        @(negedge clk);
        rst_n = 1'b1;

        //     tag       rs1           rs2           Iimm          f3         f7     reg   br    result        EQLTLTU lat hold
        run_op("add_i",  32'd5,        32'd0,        32'd7,        F3_ADD,    7'h00, 1'b0, 1'b0, 32'd12,       3'b011, 1,  0);
        run_op("mulh",   32'h80000000, 32'd2,        32'd0,        F3_MULH,   7'h01, 1'b1, 1'b0, 32'hFFFFFFFF, 3'b010, 33, 0);
        run_op("div",    32'hFFFFFFF9, 32'd2,        32'd0,        F3_DIV,    7'h01, 1'b1, 1'b0, 32'hFFFFFFFD, 3'b010, 33, 0);
        run_op("rem",    32'hFFFFFFF9, 32'd2,        32'd0,        F3_REM,    7'h01, 1'b1, 1'b0, 32'hFFFFFFFF, 3'b010, 33, 0);
        run_op("divu0",  32'd9,        32'd0,        32'd0,        F3_DIVU,   7'h01, 1'b1, 1'b0, 32'hFFFFFFFF, 3'b000, 1,  0);
        run_op("removf", 32'h80000000, 32'hFFFFFFFF, 32'd0,        F3_REM,    7'h01, 1'b1, 1'b0, 32'h0,        3'b011, 1,  0);
        run_op("sub",    32'd10,       32'd3,        32'd0,        F3_ADD,    7'h20, 1'b1, 1'b0, 32'd7,        3'b000, 1,  0);
        run_op("srai",   32'hF0000000, 32'd0,        32'h00000404, F3_SR,     7'h20, 1'b0, 1'b0, 32'hFF000000, 3'b010, 1,  0);
        run_op("sltu",   32'd3,        32'd3,        32'd0,        F3_SLTU,   7'h00, 1'b1, 1'b0, 32'd0,        3'b100, 1,  0);
        run_op("slti",   32'hFFFFFFFF, 32'd0,        32'd1,        F3_SLT,    7'h00, 1'b0, 1'b0, 32'd1,        3'b010, 1,  0);
        run_op("xori",   32'hFF00FF00, 32'd0,        32'h0F0F0F0F, F3_XOR,    7'h00, 1'b0, 1'b0, 32'hF00FF00F, 3'b010, 1,  0);
        run_op("sll",    32'd1,        32'h00000021, 32'd0,        F3_SLL,    7'h00, 1'b1, 1'b0, 32'd2,        3'b011, 1,  0);
        run_op("mul",    32'd6,        32'd7,        32'd0,        F3_MUL,    7'h01, 1'b1, 1'b0, 32'd42,       3'b011, 33, 0);
        run_op("mulhu",  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        F3_MULHU,  7'h01, 1'b1, 1'b0, 32'hFFFFFFFE, 3'b100, 33, 0);
        run_op("mulhsu", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        F3_MULHSU, 7'h01, 1'b1, 1'b0, 32'hFFFFFFFF, 3'b100, 33, 0);
        run_op("div0",   32'hFFFFFFFB, 32'd0,        32'd0,        F3_DIV,    7'h01, 1'b1, 1'b0, 32'hFFFFFFFF, 3'b010, 1,  0);
        run_op("branch", 32'd4,        32'd9,        32'd100,      F3_ADD,    7'h00, 1'b0, 1'b1, 32'd13,       3'b011, 1,  0);
        run_op("hold",   32'd100,      32'd7,        32'd0,        F3_DIVU,   7'h01, 1'b1, 1'b0, 32'd14,       3'b000, 33, 5);

        // Reset at iteration 10 of a divide
        @(negedge clk);
        drive(32'd1000, 32'd3, 32'd0, F3_DIV, 7'h01, 1'b1, 1'b0);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("mid_busy", W'(busy), W'(1));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out", aluOut, 32'h0);
        check("arst_ovld", W'(out_valid), W'(0));
        check("arst_busy", W'(busy), W'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rel_rdy", W'(in_ready), W'(1));
        stale = 1'b0;
        for (cyc = 0; cyc < 40; cyc++) begin
            stale |= out_valid;
            @(posedge clk);
            #1;
        end
        check("rel_no_stale", W'(stale), W'(0));
        run_op("post",   32'd20,       32'd0,        32'd22,       F3_ADD,    7'h00, 1'b0, 1'b0, 32'd42,       3'b011, 1,  0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
